// File: rtl/pwm_decoder.sv
// PWM decoder: measures high time and rise-to-rise period of an asynchronous PWM input.
// Define PWM_DEC_FILTER_EN to add a 3-sample glitch filter after the synchronizer.
module pwm_decoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        pwm_in,
  output logic [12:0] duty,
  output logic [12:0] period,
  output logic        valid,
  output logic        stuck,
  output logic        stuck_level
);

  typedef enum logic [1:0] {SYNC, HIGH, LOW} state_e;

  localparam logic [12:0] CNT_MAX = '1;

  logic        sync1_q, sync2_q;
  logic        s, s_prev_q;
  logic        rise_q, fall_q;
  state_e      state_q;
  logic [12:0] cnt_q, hi_cnt_q, idle_q;
  logic [12:0] cnt_inc;
  logic [12:0] duty_q, period_q;
  logic        valid_q, stuck_q, stuck_level_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pwm_in;
      sync2_q <= sync1_q;
    end
  end

`ifdef PWM_DEC_FILTER_EN
  logic [1:0] hist_q;
  logic       filt_q;

  // s follows the synchronizer only once the current and two previous samples agree
  always_comb begin
    s = filt_q;
    if ((sync2_q == hist_q[0]) && (sync2_q == hist_q[1])) s = sync2_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= '0;
      filt_q <= 1'b0;
    end else begin
      hist_q <= {hist_q[0], sync2_q};
      filt_q <= s;
    end
  end
`else
  always_comb s = sync2_q;
`endif

  // Edge flags are registered, which sets the rise-to-valid latency at three edges
  always_ff @(posedge clk) begin
    if (rst) begin
      s_prev_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      s_prev_q <= s;
      rise_q   <= s & ~s_prev_q;
      fall_q   <= ~s & s_prev_q;
    end
  end

  always_comb cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 13'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= SYNC;
      cnt_q         <= '0;
      hi_cnt_q      <= '0;
      idle_q        <= '0;
      duty_q        <= '0;
      period_q      <= '0;
      valid_q       <= 1'b0;
      stuck_q       <= 1'b0;
      stuck_level_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;

      if (rise_q || fall_q)     idle_q <= '0;
      else if (idle_q != CNT_MAX) idle_q <= idle_q + 13'd1;

      case (state_q)
        SYNC: begin
          if (rise_q) begin
            cnt_q   <= 13'd1;
            state_q <= HIGH;
          end
        end
        HIGH: begin
          cnt_q <= cnt_inc;
          if (fall_q) begin
            hi_cnt_q <= cnt_q;
            state_q  <= LOW;
          end
        end
        LOW: begin
          cnt_q <= cnt_inc;
          if (rise_q) begin
            period_q <= cnt_q;
            duty_q   <= hi_cnt_q;
            valid_q  <= 1'b1;
            stuck_q  <= 1'b0;
            cnt_q    <= 13'd1;
            state_q  <= HIGH;
          end
        end
        default: state_q <= SYNC;
      endcase

      // Idle timeout overrides the FSM; it cannot coincide with a valid since that needs an edge
      if ((idle_q == CNT_MAX) && !(rise_q || fall_q)) begin
        stuck_q       <= 1'b1;
        stuck_level_q <= s;
        state_q       <= SYNC;
      end
    end
  end

  assign duty        = duty_q;
  assign period      = period_q;
  assign valid       = valid_q;
  assign stuck       = stuck_q;
  assign stuck_level = stuck_level_q;

endmodule

// File: tb/tb_pwm_decoder.sv
// Scoreboard bench for pwm_decoder; expected measurements are queued as rises are driven.
// Build with PWM_DEC_FILTER_EN defined to exercise the glitch-filter configuration.
module tb_pwm_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        pwm_in;
  logic [12:0] duty, period;
  logic        valid, stuck, stuck_level;

  always #5 clk = ~clk;

  pwm_decoder dut (
    .clk        (clk),
    .rst        (rst),
    .pwm_in     (pwm_in),
    .duty       (duty),
    .period     (period),
    .valid      (valid),
    .stuck      (stuck),
    .stuck_level(stuck_level)
  );

`ifdef PWM_DEC_FILTER_EN
  localparam int unsigned LAT = 5, SDLY = 2, CMP_LO = 3, CMP_HI = 4093;
`else
  localparam int unsigned LAT = 3, SDLY = 0, CMP_LO = 1, CMP_HI = 4095;
`endif

  typedef struct packed {
    logic [12:0] d;
    logic [12:0] p;
  } meas_t;

  meas_t       exp_q[$];
  meas_t       mon_m;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic        lvl;
  logic        armed;
  int unsigned hi_acc, per_acc;
  logic        prev_valid;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Drive a level for n cycles; a rise closes the period in progress and queues its measurement
  task automatic hold(input logic v, input int unsigned n);
    meas_t m;
    if (v && !lvl) begin
      if (armed) begin
        m.d = hi_acc[12:0];
        m.p = per_acc[12:0];
        exp_q.push_back(m);
      end
      armed   = 1'b1;
      hi_acc  = 0;
      per_acc = 0;
    end
    lvl     = v;
    pwm_in  = v;
    per_acc += n;
    if (v) hi_acc += n;
    repeat (n) @(negedge clk);
  endtask

  task automatic pwm_run(input int unsigned cmp, input int unsigned per, input int unsigned n);
    for (int i = 0; i < int'(n); i++) begin
      hold(1'b1, cmp);
      hold(1'b0, per - cmp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_duty"},   duty,        0);
    check({tag, "_period"}, period,      0);
    check({tag, "_valid"},  valid,       0);
    check({tag, "_stuck"},  stuck,       0);
    check({tag, "_level"},  stuck_level, 0);
  endtask

  always @(negedge clk) begin
    if (!rst && valid) begin
      check("valid_width", prev_valid, 0);
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        mon_m = exp_q.pop_front();
        check("duty", duty, mon_m.d);
        check("period", period, mon_m.p);
        check("stuck_on_valid", stuck, 0);
      end
    end
    prev_valid <= valid;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst    = 1'b1;
    pwm_in = 1'b0;
    lvl    = 1'b0;
    armed  = 1'b0;
    hi_acc = 0;
    per_acc = 0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;

    // Latency: first rise arms, the next rise (edge N) yields valid after edge N+LAT
    hold(1'b1, 10);
    hold(1'b0, 10);
    hold(1'b1, LAT);
    check("lat_early", valid, 0);
    hold(1'b1, 1);
    check("lat_valid", valid, 1);
    hold(1'b0, 10);

`ifdef PWM_DEC_FILTER_EN
    hold(1'b1, 3);
    hold(1'b0, 10);
    hold(1'b1, 50);
    pwm_in = 1'b0;
    repeat (2) @(negedge clk);
    pwm_in = 1'b1;
    hi_acc  += 2;
    per_acc += 2;
    hold(1'b1, 48);
    hold(1'b0, 100);
`else
    hold(1'b1, 1);
    hold(1'b0, 6);
    hold(1'b1, 6);
    hold(1'b0, 1);
    hold(1'b1, 4);
    hold(1'b0, 4);
`endif

    pwm_run(1024, 4096, 3);
    pwm_run(CMP_HI, 4096, 2);
    pwm_run(CMP_LO, 4096, 2);

    // Input stops low after a partial high phase: stuck at exactly 8196+SDLY edges after the fall
    hold(1'b1, 20);
    pwm_in = 1'b0;
    lvl    = 1'b0;
    armed  = 1'b0;
    repeat (8195 + SDLY) @(negedge clk);
    check("stuck_early", stuck, 0);
    @(negedge clk);
    check("stuck_low", stuck, 1);
    check("stuck_low_level", stuck_level, 0);
    check("stuck_hold_duty", duty, CMP_LO);
    check("stuck_hold_period", period, 4096);

    // Held high long enough to re-report stuck at level 1, then recover on a 200/500 waveform
    hold(1'b1, 9000);
    check("stuck_high", stuck, 1);
    check("stuck_high_level", stuck_level, 1);
    armed = 1'b0;
    hold(1'b0, 300);
    hold(1'b1, 200);
    hold(1'b0, 300);
    hold(1'b1, LAT);
    check("stuck_before_valid", stuck, 1);
    hold(1'b1, 1);
    check("recover_valid", valid, 1);
    check("recover_stuck", stuck, 0);
    hold(1'b1, 200 - LAT - 1);
    hold(1'b0, 300);

    // Reset mid-high: synchronizer restarts at 0, so the still-high input reads as a fresh rise
    pwm_run(200, 500, 2);
    hold(1'b1, 100);
    rst = 1'b1;
    @(negedge clk);
    check_outputs_zero("midrst");
    rst     = 1'b0;
    armed   = 1'b1;
    hi_acc  = 0;
    per_acc = 0;
    hold(1'b1, 50);
    hold(1'b0, 300);
    pwm_run(200, 500, 3);
    hold(1'b1, 10);
    hold(1'b0, 20);

    check("drain", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
